host_job_sequencer: RTL and testbench
=====================================

HOST_JOB_SEQUENCER -- requirements
Module: host_job_sequencer

Interface
REQ-001 Parameter POLL_GAP, default 4, idle cycles between the command write and the first status read, and between consecutive status reads (0 allowed).
REQ-002 Parameter TIMEOUT_POLLS, default 1024, maximum status reads per job before timeout (>=1).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 resetn  in  1  synchronous active-low reset.
REQ-005 job_valid_in  in  1  job request valid.
REQ-006 job_ready_out  out  1  sequencer idle; job accepted on valid&ready.
REQ-007 job_row_cnt_in  in  [1:0][7:0]  row counts, operands 0/1.
REQ-008 job_col_cnt_in  in  [1:0][7:0]  column counts, operands 0/1.
REQ-009 host_wren_out  out  1  register write strobe, one cycle per write.
REQ-010 host_addr_wr_out  out  32  register write address.
REQ-011 host_data_wr_out  out  32  register write data.
REQ-012 host_rden_out  out  1  register read strobe.
REQ-013 host_addr_rd_out  out  32  register read address.
REQ-014 host_data_rd_in  in  32  read data, valid in the same cycle as host_rden_out.
REQ-015 done_out  out  1  one-cycle job-complete pulse.
REQ-016 err_code_out  out  2  00 ok, 01 bad FPGA signature, 10 timeout; held until next job accepted.
REQ-017 status_out  out  32  last status word read; held until next read.

Function
REQ-018 Register map: COMMAND 0x000C_0000, INFO 0x000C_0004, STATUS 0x000C_0008; STATUS[7:0]=0xFC signature, STATUS[8]=ready.
REQ-019 All outputs registered; when no access is issued, wren/rden=0 and write/read address and data=0.
REQ-020 States: IDLE, WR_INFO, WR_CMD, GAP, RD_STAT, CLR_CMD, DONE.
REQ-021 IDLE: job_ready_out=1; on valid&ready, capture counts, clear err_code_out, -> WR_INFO; job_ready_out=0 in all other states.
REQ-022 WR_INFO (1 cycle): wren=1, addr INFO, data {col[1],row[1],col[0],row[0]} (row[0] in [7:0]); -> WR_CMD.
REQ-023 WR_CMD (1 cycle): wren=1, addr COMMAND, data 0x0000_01AC; poll counter cleared; -> GAP, or RD_STAT if POLL_GAP=0.
REQ-024 GAP: count POLL_GAP cycles with no access, then -> RD_STAT.
REQ-025 RD_STAT (1 cycle): rden=1, addr STATUS; sample host_data_rd_in into status_out that cycle.
REQ-026 RD_STAT decision, priority order: [7:0]!=0xFC -> err 01, CLR_CMD; [8]=1 -> err 00, CLR_CMD; poll count = TIMEOUT_POLLS-1 -> err 10, CLR_CMD; else increment poll count, -> GAP.
REQ-027 CLR_CMD (1 cycle): wren=1, addr COMMAND, data 0x0000_0000; always executed, including error exits; -> DONE.
REQ-028 DONE (1 cycle): done_out=1; -> IDLE; the next job is accepted no earlier than the following cycle.
REQ-029 Latency, accept edge = cycle 0: WR_INFO cycle 1, WR_CMD cycle 2, first RD_STAT cycle 3+POLL_GAP, polls every POLL_GAP+1 cycles; CLR_CMD the cycle after the terminating read; DONE one cycle later.
REQ-030 job_valid_in while busy is ignored (not queued); job inputs are sampled only at acceptance.
REQ-031 Read and write strobes are never asserted in the same cycle.

Reset
REQ-032 resetn=0 at a clock edge -> state IDLE; job_ready_out=1 from the first cycle after reset deasserts; done_out=0, err_code_out=00, status_out=0, all bus outputs 0, counters 0.
REQ-033 Reset mid-job aborts immediately with no CLR_CMD write; recovery is the target block's own reset.

Verification
REQ-034 Nominal, POLL_GAP=4: rows {3,5}, cols {7,2}; responder returns 0x1FC on the 2nd read -> writes INFO=0x0205_0703 (cycle 1), CMD=0x1AC (cycle 2), reads at cycles 7 and 12, CMD=0 at 13, done at 14, err 00.
REQ-035 Signature fault: status reads 0x0000_01AB -> exactly one read, CMD=0 write, done with err 01, status_out=0x0000_01AB.
REQ-036 Timeout, TIMEOUT_POLLS=3: status stuck at 0x0FC -> exactly 3 reads, CMD=0 write, done with err 10.
REQ-037 POLL_GAP=0 with status 0x1FC: read in cycle 3 (immediately after CMD write), CMD=0 in 4, done in 5.
REQ-038 job_valid_in held high through a job and reset asserted mid-GAP -> the second job is not accepted during the first; after reset: all outputs 0, job_ready_out=1, no clear write issued.

Source files
------------

// File: rtl/host_job_sequencer.sv
// Host-side job sequencer: programs INFO/COMMAND registers of a target block,
// polls STATUS until ready, signature fault or timeout, then clears COMMAND.
module host_job_sequencer #(
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            job_valid_in,
  output logic            job_ready_out,
  input  logic [1:0][7:0] job_row_cnt_in,
  input  logic [1:0][7:0] job_col_cnt_in,
  output logic            host_wren_out,
  output logic [31:0]     host_addr_wr_out,
  output logic [31:0]     host_data_wr_out,
  output logic            host_rden_out,
  output logic [31:0]     host_addr_rd_out,
  input  logic [31:0]     host_data_rd_in,
  output logic            done_out,
  output logic [1:0]      err_code_out,
  output logic [31:0]     status_out
);

  localparam logic [31:0] AddrCommand = 32'h000C_0000;
  localparam logic [31:0] AddrInfo    = 32'h000C_0004;
  localparam logic [31:0] AddrStatus  = 32'h000C_0008;
  localparam logic [31:0] CmdStart    = 32'h0000_01AC;
  localparam logic [7:0]  Signature   = 8'hFC;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrSig     = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  localparam int unsigned GapW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned PollW = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;
  localparam logic [GapW-1:0]  GapLast  = GapW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [PollW-1:0] PollLast = PollW'(TIMEOUT_POLLS - 1);

  typedef enum logic [2:0] {
    StIdle, StWrInfo, StWrCmd, StGap, StRdStat, StClrCmd, StDone
  } state_e;

  // With no gap configured, a non-terminal poll goes straight to the next read.
  localparam state_e PollNext = (POLL_GAP == 0) ? StRdStat : StGap;

  state_e           state_q, state_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic [1:0][7:0]  row_q, row_d, col_q, col_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      status_q, status_d;

  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        wren_q, wren_d;
  logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d;
  logic        rden_q, rden_d;
  logic [31:0] raddr_q, raddr_d;

  // State, counters and job context registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      err_q      <= ErrOk;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      err_q      <= err_d;
      status_q   <= status_d;
    end
  end

  // Next-state and datapath updates; the status decision uses read data combinationally.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    poll_cnt_d = poll_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    err_d      = err_q;
    status_d   = status_q;
    case (state_q)
      StIdle: begin
        if (job_valid_in) begin
          row_d   = job_row_cnt_in;
          col_d   = job_col_cnt_in;
          err_d   = ErrOk;
          state_d = StWrInfo;
        end
      end
      StWrInfo: state_d = StWrCmd;
      StWrCmd: begin
        poll_cnt_d = '0;
        gap_cnt_d  = '0;
        state_d    = PollNext;
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          state_d   = StRdStat;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StRdStat: begin
        status_d = host_data_rd_in;
        if (host_data_rd_in[7:0] != Signature) begin
          err_d   = ErrSig;
          state_d = StClrCmd;
        end else if (host_data_rd_in[8]) begin
          err_d   = ErrOk;
          state_d = StClrCmd;
        end else if (poll_cnt_q == PollLast) begin
          err_d   = ErrTimeout;
          state_d = StClrCmd;
        end else begin
          poll_cnt_d = poll_cnt_q + PollW'(1);
          gap_cnt_d  = '0;
          state_d    = PollNext;
        end
      end
      StClrCmd: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    wren_d  = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    rden_d  = 1'b0;
    raddr_d = '0;
    ready_d = (state_d == StIdle);
    done_d  = (state_d == StDone);
    case (state_d)
      StWrInfo: begin
        wren_d  = 1'b1;
        waddr_d = AddrInfo;
        wdata_d = {col_d[1], row_d[1], col_d[0], row_d[0]};
      end
      StWrCmd: begin
        wren_d  = 1'b1;
        waddr_d = AddrCommand;
        wdata_d = CmdStart;
      end
      StRdStat: begin
        rden_d  = 1'b1;
        raddr_d = AddrStatus;
      end
      StClrCmd: begin
        wren_d  = 1'b1;
        waddr_d = AddrCommand;
      end
      default: ;
    endcase
  end

  // Registered bus and handshake outputs; ready comes out of reset high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rden_q  <= 1'b0;
      raddr_q <= '0;
    end else begin
      ready_q <= ready_d;
      done_q  <= done_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rden_q  <= rden_d;
      raddr_q <= raddr_d;
    end
  end

  assign job_ready_out    = ready_q;
  assign done_out         = done_q;
  assign host_wren_out    = wren_q;
  assign host_addr_wr_out = waddr_q;
  assign host_data_wr_out = wdata_q;
  assign host_rden_out    = rden_q;
  assign host_addr_rd_out = raddr_q;
  assign err_code_out     = err_q;
  assign status_out       = status_q;

endmodule

// File: tb/tb_host_job_sequencer.sv
// Bench for host_job_sequencer: two instances (POLL_GAP=4 and POLL_GAP=0,
// both TIMEOUT_POLLS=3) driven by directed and randomized jobs.
module tb_host_job_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  int              sel;
  logic            job_valid;
  logic [1:0][7:0] rows, cols;

  logic a_valid, a_ready, a_wren, a_rden, a_done;
  logic b_valid, b_ready, b_wren, b_rden, b_done;
  logic [31:0] a_waddr, a_wdata, a_raddr, a_rdata, a_status;
  logic [31:0] b_waddr, b_wdata, b_raddr, b_rdata, b_status;
  logic [1:0]  a_err, b_err;

  // Selected-instance view
  logic        o_ready, o_wren, o_rden, o_done;
  logic [31:0] o_waddr, o_wdata, o_raddr, o_status;
  logic [1:0]  o_err;

  // Status responder: returns resp_words in order, repeating the last one
  logic [31:0] resp_words [8];
  int          resp_n = 1;
  int          rd_idx = 0;
  logic        clr_idx;
  logic [31:0] resp_word;

  int checks = 0;
  int errors = 0;

  assign a_valid = job_valid && (sel == 0);
  assign b_valid = job_valid && (sel == 1);
  assign resp_word = resp_words[(rd_idx < resp_n) ? rd_idx : resp_n - 1];
  assign a_rdata = a_rden ? resp_word : 32'h0;
  assign b_rdata = b_rden ? resp_word : 32'h0;

  always_comb begin
    if (sel == 0) begin
      o_ready = a_ready; o_wren = a_wren; o_rden = a_rden; o_done = a_done;
      o_waddr = a_waddr; o_wdata = a_wdata; o_raddr = a_raddr;
      o_status = a_status; o_err = a_err;
    end else begin
      o_ready = b_ready; o_wren = b_wren; o_rden = b_rden; o_done = b_done;
      o_waddr = b_waddr; o_wdata = b_wdata; o_raddr = b_raddr;
      o_status = b_status; o_err = b_err;
    end
  end

  always @(posedge clk) begin
    if (clr_idx) rd_idx <= 0;
    else if (o_rden) rd_idx <= rd_idx + 1;
  end

  host_job_sequencer #(.POLL_GAP(4), .TIMEOUT_POLLS(3)) dut_a (
    .clk(clk), .resetn(resetn),
    .job_valid_in(a_valid), .job_ready_out(a_ready),
    .job_row_cnt_in(rows), .job_col_cnt_in(cols),
    .host_wren_out(a_wren), .host_addr_wr_out(a_waddr), .host_data_wr_out(a_wdata),
    .host_rden_out(a_rden), .host_addr_rd_out(a_raddr), .host_data_rd_in(a_rdata),
    .done_out(a_done), .err_code_out(a_err), .status_out(a_status)
  );

  host_job_sequencer #(.POLL_GAP(0), .TIMEOUT_POLLS(3)) dut_b (
    .clk(clk), .resetn(resetn),
    .job_valid_in(b_valid), .job_ready_out(b_ready),
    .job_row_cnt_in(rows), .job_col_cnt_in(cols),
    .host_wren_out(b_wren), .host_addr_wr_out(b_waddr), .host_data_wr_out(b_wdata),
    .host_rden_out(b_rden), .host_addr_rd_out(b_raddr), .host_data_rd_in(b_rdata),
    .done_out(b_done), .err_code_out(b_err), .status_out(b_status)
  );

  // Runs one job on instance s and checks every cycle against a timeline
  // derived from the poll schedule and the responder contents.
  task automatic run_job(input int s, input logic [7:0] r0, input logic [7:0] r1,
                         input logic [7:0] c0, input logic [7:0] c1, input bit hold);
    int g, nreads, last, clr_c, done_c;
    logic [1:0]  exp_err;
    logic [31:0] w, exp_status;
    logic        exp_wr, exp_rd;
    logic [31:0] exp_waddr, exp_wdata, exp_raddr;
    logic [97:0] obs_bus, exp_bus;
    sel = s;
    g = (s == 0) ? 4 : 0;
    nreads = 0; exp_err = 2'b10; exp_status = 32'h0;
    for (int i = 0; i < 3; i++) begin
      w = resp_words[(i < resp_n) ? i : resp_n - 1];
      nreads = i + 1;
      exp_status = w;
      if (w[7:0] != 8'hFC) begin exp_err = 2'b01; break; end
      if (w[8]) begin exp_err = 2'b00; break; end
    end
    last   = 3 + g + (nreads - 1) * (g + 1);
    clr_c  = last + 1;
    done_c = clr_c + 1;

    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready sel=%0d got %b want 1", s, o_ready);
    end
    job_valid = 1'b1;
    rows = {r1, r0};
    cols = {c1, c0};
    clr_idx = 1'b1;
    @(posedge clk);
    #1;
    clr_idx = 1'b0;
    if (hold) begin
      rows = 16'($urandom);
      cols = 16'($urandom);
    end else begin
      job_valid = 1'b0;
    end

    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      exp_wr = (c == 1) || (c == 2) || (c == clr_c);
      exp_rd = (c >= 3 + g) && (c <= last) && (((c - 3 - g) % (g + 1)) == 0);
      exp_waddr = (c == 1) ? 32'h000C_0004 : (exp_wr ? 32'h000C_0000 : 32'h0);
      exp_wdata = (c == 1) ? {c1, r1, c0, r0} : ((c == 2) ? 32'h0000_01AC : 32'h0);
      exp_raddr = exp_rd ? 32'h000C_0008 : 32'h0;
      obs_bus = {o_wren, o_waddr, o_wdata, o_rden, o_raddr};
      exp_bus = {exp_wr, exp_waddr, exp_wdata, exp_rd, exp_raddr};
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++;
        $display("FAIL bus sel=%0d cycle=%0d got wr=%b %h %h rd=%b %h want wr=%b %h %h rd=%b %h",
                 s, c, o_wren, o_waddr, o_wdata, o_rden, o_raddr,
                 exp_wr, exp_waddr, exp_wdata, exp_rd, exp_raddr);
      end
      checks++;
      if ({o_ready, o_done} !== {1'b0, (c == done_c)}) begin
        errors++;
        $display("FAIL ready_done sel=%0d cycle=%0d got %b%b want 0%b",
                 s, c, o_ready, o_done, (c == done_c));
      end
    end
    checks++;
    if (o_err !== exp_err) begin
      errors++;
      $display("FAIL err_at_done sel=%0d got %b want %b", s, o_err, exp_err);
    end

    @(negedge clk);
    checks++;
    if ({o_ready, o_done, o_wren, o_rden, o_err, o_status} !==
        {1'b1, 1'b0, 1'b0, 1'b0, exp_err, exp_status}) begin
      errors++;
      $display("FAIL post_job sel=%0d got rdy=%b done=%b wr=%b rd=%b err=%b st=%h want 1 0 0 0 %b %h",
               s, o_ready, o_done, o_wren, o_rden, o_err, o_status, exp_err, exp_status);
    end
    job_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, a_done, a_wren, a_waddr, a_wdata, a_rden, a_raddr, a_err, a_status} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_a got rdy=%b done=%b wr=%b rd=%b err=%b st=%h want 1 0 0 0 00 0",
               a_ready, a_done, a_wren, a_rden, a_err, a_status);
    end
    checks++;
    if ({b_ready, b_done, b_wren, b_waddr, b_wdata, b_rden, b_raddr, b_err, b_status} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_b got rdy=%b done=%b wr=%b rd=%b err=%b st=%h want 1 0 0 0 00 0",
               b_ready, b_done, b_wren, b_rden, b_err, b_status);
    end
  endtask

  task automatic test_nominal();
    resp_n = 2; resp_words[0] = 32'h0000_00FC; resp_words[1] = 32'h0000_01FC;
    run_job(0, 8'd3, 8'd5, 8'd7, 8'd2, 1'b0);
  endtask

  task automatic test_sig_fault();
    resp_n = 1; resp_words[0] = 32'h0000_01AB;
    run_job(0, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
  endtask

  task automatic test_timeout();
    resp_n = 1; resp_words[0] = 32'h0000_00FC;
    run_job(0, 8'hAA, 8'h55, 8'h0F, 8'hF0, 1'b0);
  endtask

  task automatic test_zero_gap();
    resp_n = 1; resp_words[0] = 32'h0000_01FC;
    run_job(1, 8'd9, 8'd8, 8'd7, 8'd6, 1'b0);
    resp_n = 1; resp_words[0] = 32'h0000_00FC;
    run_job(1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
  endtask

  task automatic test_random();
    int k;
    logic [7:0] lb;
    for (int j = 0; j < 40; j++) begin
      resp_n = $urandom_range(1, 4);
      for (int i = 0; i < resp_n; i++) begin
        k = $urandom_range(0, 9);
        lb = 8'($urandom);
        if (lb == 8'hFC) lb = 8'h00;
        if (k == 0)      resp_words[i] = {23'($urandom), 1'($urandom), lb};
        else if (k <= 3) resp_words[i] = {23'($urandom), 1'b1, 8'hFC};
        else             resp_words[i] = {23'($urandom), 1'b0, 8'hFC};
      end
      run_job(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 1'($urandom));
    end
  endtask

  // Valid held high through a job, then reset lands in the second poll gap.
  task automatic test_reset_mid_job();
    sel = 0;
    resp_n = 1; resp_words[0] = 32'h0000_00FC;
    @(negedge clk);
    job_valid = 1'b1; rows = {8'd4, 8'd4}; cols = {8'd4, 8'd4}; clr_idx = 1'b1;
    @(posedge clk);
    #1;
    clr_idx = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b0 || (c >= 3 && o_wren !== 1'b0)) begin
        errors++;
        $display("FAIL busy_hold cycle=%0d got rdy=%b wr=%b want 0 0", c, o_ready, o_wren);
      end
    end
    resetn = 1'b0;
    job_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({a_ready, a_done, a_wren, a_waddr, a_wdata, a_rden, a_raddr, a_err, a_status} !==
          {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0}) begin
        errors++;
        $display("FAIL after_reset step=%0d got rdy=%b wr=%b %h %h rd=%b err=%b st=%h want idle zeros",
                 c, a_ready, a_wren, a_waddr, a_wdata, a_rden, a_err, a_status);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    resetn = 1'b0; sel = 0; job_valid = 1'b0; clr_idx = 1'b0;
    rows = '0; cols = '0;
    for (int i = 0; i < 8; i++) resp_words[i] = 32'h0;
    test_reset();
    test_nominal();
    test_sig_fault();
    test_timeout();
    test_zero_gap();
    test_random();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
